// File: rtl/branch_logic_unit.sv
// Purpose: EX-stage branch decision; compares forwarded rs1/rs2 under a 4-bit branch opcode.
// Latency: out is combinational (0 cycles); out_q is out registered one clk edge later.
// Backpressure: none; the decision is produced every cycle with no handshake.
module branch_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       op,
  output logic             out,
  output logic             out_q
);

  // Opcode encodings; op[3] is the branch-enable bit.
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_JAL  = 4'b1010;
  localparam logic [3:0] OP_RSVD = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BGE  = 4'b1101;
  localparam logic [3:0] OP_BLTU = 4'b1110;
  localparam logic [3:0] OP_BGEU = 4'b1111;

  logic eq;
  logic lt_s;
  logic lt_u;

  // Direct comparators; no subtract-and-test-sign, so no overflow corner cases.
  always_comb begin
    eq   = (data1 == data2);
    lt_s = ($signed(data1) < $signed(data2));
    lt_u = (data1 < data2);
  end

  // Take-branch decode; default 0 covers disabled codes, the reserved code and X/Z on op.
  always_comb begin
    out = 1'b0;
    case (op)
      OP_BEQ:  out = eq;
      OP_BNE:  out = ~eq;
      OP_JAL:  out = 1'b1;
      OP_RSVD: out = 1'b0;
      OP_BLT:  out = lt_s;
      OP_BGE:  out = ~lt_s;
      OP_BLTU: out = lt_u;
      OP_BGEU: out = ~lt_u;
      default: out = 1'b0;
    endcase
  end

  // Registered copy for next-stage flush bookkeeping; reset clears it without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_branch_logic_unit.sv
// Purpose: directed table, reset/registered-path sequences and random sweep for branch_logic_unit.
// Latency: checks out 1 time unit after inputs settle, out_q 1 time unit after each rising edge.
// Backpressure: none; inputs are driven on the falling edge every cycle.
module tb_branch_logic_unit;

  logic        clk;
  logic        reset;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  op;
  logic        out;
  logic        out_q;

  int checks = 0;
  int errors = 0;

  branch_logic_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .data1 (data1),
    .data2 (data2),
    .op    (op),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        exp;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b (op=%b d1=%h d2=%h)", name, act, exp, op, data1, data2);
    end
  endtask

  // Reference: signed order obtained by flipping sign bits and comparing unsigned.
  function automatic logic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] af;
    logic [31:0] bf;
    af = a ^ 32'h8000_0000;
    bf = b ^ 32'h8000_0000;
    case (o)
      4'h8:    return a == b;
      4'h9:    return a != b;
      4'hA:    return 1'b1;
      4'hC:    return af < bf;
      4'hD:    return !(af < bf);
      4'hE:    return a < b;
      4'hF:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    data1 = a;
    data2 = b;
  endtask

  initial begin
    logic prev;
    logic [3:0] rop;

    vecs[0]  = '{"beq_eq",     4'b1000, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[1]  = '{"bne_eq",     4'b1001, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2]  = '{"beq_ne",     4'b1000, 32'h1234_5678, 32'h8765_4321, 1'b0};
    vecs[3]  = '{"bne_ne",     4'b1001, 32'h1234_5678, 32'h8765_4321, 1'b1};
    vecs[4]  = '{"blt_neg",    4'b1100, 32'h8000_0000, 32'h0000_0001, 1'b1};
    vecs[5]  = '{"bge_pos",    4'b1101, 32'h0000_0001, 32'h8000_0000, 1'b1};
    vecs[6]  = '{"blt_eq",     4'b1100, 32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[7]  = '{"bge_eq",     4'b1101, 32'h0000_0005, 32'h0000_0005, 1'b1};
    vecs[8]  = '{"bltu",       4'b1110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{"bgeu",       4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[10] = '{"bltu_swap",  4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[11] = '{"bgeu_swap",  4'b1111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{"bltu_eq",    4'b1110, 32'h0000_0007, 32'h0000_0007, 1'b0};
    vecs[13] = '{"bgeu_eq",    4'b1111, 32'h0000_0007, 32'h0000_0007, 1'b1};
    vecs[14] = '{"jal_zero",   4'b1010, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[15] = '{"jal_any",    4'b1010, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1};
    vecs[16] = '{"disabled",   4'b0000, 32'h0000_0001, 32'h0000_0002, 1'b0};
    vecs[17] = '{"reserved",   4'b1011, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[18] = '{"blt_negneg", 4'b1100, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1};
    vecs[19] = '{"bge_maxmin", 4'b1101, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[20] = '{"blt_maxmin", 4'b1100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0};

    reset = 1'b1;
    drive(4'b0000, 32'h0, 32'h0);
    #1;
    check("reset_out_q", out_q, 1'b0);

    // Directed table (reset held so out_q stays quiet).
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].op, vecs[i].d1, vecs[i].d2);
      #1;
      check(vecs[i].name, out, vecs[i].exp);
    end

    // op[3] = 0 sweep with random operands.
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        drive(4'(c), $urandom, $urandom);
        #1;
        check("op3_clear", out, 1'b0);
      end
    end

    // Unknown opcode must decode to no-branch.
    op = 4'bxxxx;
    #1;
    check("op_x", out, 1'b0);

    // Registered path: release, JAL captured on first edge.
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1010, 32'h0, 32'h0);
    #1;
    check("outq_before_edge", out_q, 1'b0);
    @(posedge clk);
    #1;
    check("outq_jal", out_q, 1'b1);

    // Mid-cycle reset clears out_q without an edge; out unaffected.
    #2;
    reset = 1'b1;
    #1;
    check("outq_async_reset", out_q, 1'b0);
    check("out_during_reset", out, 1'b1);
    @(posedge clk);
    #1;
    check("outq_held_in_reset", out_q, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("outq_after_release", out_q, 1'b1);
    @(negedge clk);
    drive(4'b0000, 32'h1, 32'h2);
    #1;
    check("outq_hold_until_edge", out_q, 1'b1);
    @(posedge clk);
    #1;
    check("outq_disabled", out_q, 1'b0);

    // Random sweep against the reference model.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       drive(rop, $urandom, $urandom);
        1:       begin data1 = $urandom; drive(rop, data1, data1); end
        2:       drive(rop, {1'b1, 31'($urandom)}, {1'b0, 31'($urandom)});
        default: drive(rop, $urandom & 32'h8000_000F, $urandom & 32'h8000_000F);
      endcase
      #1;
      prev = model(op, data1, data2);
      check("rand_out", out, prev);
      @(posedge clk);
      #1;
      check("rand_out_q", out_q, prev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1);
  end

endmodule
